// File: rtl/block_pkg.sv
// Shared types and sizes for the block slot scheduler and its slot bank.
package block_pkg;

  localparam int NUM_SLOTS  = 12;
  localparam int NUM_BLOCKS = 256;
  localparam int WINDOW_Z   = 2048;

  localparam int X_W    = 12;
  localparam int Y_W    = 12;
  localparam int Z_W    = 14;
  localparam int DIR_W  = 3;
  localparam int ID_W   = 8;
  localparam int SLOT_W = 4;
  localparam int CNT_W  = 9;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [Z_W-1:0]   z;
    logic             color;
    logic [DIR_W-1:0] direction;
    logic [ID_W-1:0]  id;
    logic             visible;
  } block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    READY = 2'd3
  } sched_state_t;

  // Window upper bound is formed at Z_W+1 bits so it cannot wrap
  function automatic logic z_in_window(input logic [Z_W-1:0] z, input logic [Z_W-1:0] cam);
    logic [Z_W:0] hi;
    hi = {1'b0, cam} + (Z_W+1)'(WINDOW_Z);
    return (z >= cam) && ({1'b0, z} < hi);
  endfunction

endpackage

// File: rtl/block_slot_scheduler_slot_bank.sv
// Shadow and active slot arrays; the active bank only changes on swap.
// Exposes shadow Z values when NEAREST_REPLACE_EN is defined.
module slot_bank
  import block_pkg::*;
(
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       wr_en,
  input  logic [SLOT_W-1:0]          wr_idx,
  input  block_t                     wr_data,
  input  logic                       clear_shadow,
  input  logic                       swap,
`ifdef NEAREST_REPLACE_EN
  output logic [NUM_SLOTS*Z_W-1:0]   shadow_z,
`endif
  output logic [NUM_SLOTS*X_W-1:0]   block_x,
  output logic [NUM_SLOTS*Y_W-1:0]   block_y,
  output logic [NUM_SLOTS*Z_W-1:0]   block_z,
  output logic [NUM_SLOTS-1:0]       block_color,
  output logic [NUM_SLOTS*DIR_W-1:0] block_direction,
  output logic [NUM_SLOTS*ID_W-1:0]  block_id,
  output logic [NUM_SLOTS-1:0]       block_visible
);

  block_t shadow_r [NUM_SLOTS];
  block_t active_r [NUM_SLOTS];

  // Bank storage: swap reads the pre-clear shadow in the same edge
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow_r[i] <= '0;
        active_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (swap) begin
          active_r[i] <= shadow_r[i];
        end
        if (clear_shadow) begin
          shadow_r[i].visible <= 1'b0;
        end else if (wr_en && (wr_idx == SLOT_W'(i))) begin
          shadow_r[i] <= wr_data;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_unpack
    assign block_x[i*X_W +: X_W]           = active_r[i].x;
    assign block_y[i*Y_W +: Y_W]           = active_r[i].y;
    assign block_z[i*Z_W +: Z_W]           = active_r[i].z;
    assign block_color[i]                  = active_r[i].color;
    assign block_direction[i*DIR_W +: DIR_W] = active_r[i].direction;
    assign block_id[i*ID_W +: ID_W]        = active_r[i].id;
    assign block_visible[i]                = active_r[i].visible;
`ifdef NEAREST_REPLACE_EN
    assign shadow_z[i*Z_W +: Z_W]          = shadow_r[i].z;
`endif
  end

endmodule

// File: rtl/block_slot_scheduler.sv
// Per-frame closest-block slot scheduler: scans block memory into a shadow bank and
// swaps it into the active bank at frame start. Option macro: NEAREST_REPLACE_EN.
module block_slot_scheduler
  import block_pkg::*;
(
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         frame_start_in,
  input  logic [13:0]  cam_z_in,
  output logic [7:0]   mem_addr_out,
  output logic         mem_rd_out,
  input  logic         mem_valid_in,
  input  logic [11:0]  mem_x_in,
  input  logic [11:0]  mem_y_in,
  input  logic [13:0]  mem_z_in,
  input  logic         mem_color_in,
  input  logic [2:0]   mem_direction_in,
  input  logic         mem_visible_in,
  output logic [143:0] block_x_out,
  output logic [143:0] block_y_out,
  output logic [167:0] block_z_out,
  output logic [11:0]  block_color_out,
  output logic [35:0]  block_direction_out,
  output logic [95:0]  block_ID_out,
  output logic [11:0]  block_visible_out,
  output logic         swap_out,
  output logic         busy_out,
  output logic         overflow_out,
  output logic         late_out
);

  localparam logic [7:0]        LAST_ADDR  = 8'(NUM_BLOCKS - 1);
  localparam logic [CNT_W-1:0]  ALL_BLOCKS = CNT_W'(NUM_BLOCKS);
  localparam logic [SLOT_W-1:0] SLOTS_FULL = SLOT_W'(NUM_SLOTS);

  sched_state_t      state_r, next_state_s;
  logic [7:0]        issue_cnt_r;
  logic [CNT_W-1:0]  resp_cnt_r;
  logic [SLOT_W-1:0] fill_cnt_r;
  logic [Z_W-1:0]    cam_z_r;
  logic              resp_en_r, rd_r, busy_r, swap_r, overflow_r, late_r;
  logic              scan_start_s, do_swap_s, late_set_s, last_issue_s;
  logic              beat_s, eligible_s, full_s, fill_s, drop_s, wr_en_s;
  logic [SLOT_W-1:0] wr_idx_s;
  block_t            wr_data_s;

`ifdef NEAREST_REPLACE_EN
  logic [NUM_SLOTS*Z_W-1:0] shadow_z_s;
  logic [Z_W-1:0]           max_z_s, max_z_r, max_z_eff_s;
  logic [SLOT_W-1:0]        max_idx_s, max_idx_r, max_idx_eff_s;
  logic                     wr_last_r;

  // Largest shadow Z (lowest index on ties); bypass the register right after a write
  always_comb begin
    max_z_s   = shadow_z_s[Z_W-1:0];
    max_idx_s = {SLOT_W{1'b0}};
    for (int i = 1; i < NUM_SLOTS; i++) begin
      if (shadow_z_s[i*Z_W +: Z_W] > max_z_s) begin
        max_z_s   = shadow_z_s[i*Z_W +: Z_W];
        max_idx_s = SLOT_W'(i);
      end else begin
        max_z_s   = max_z_s;
        max_idx_s = max_idx_s;
      end
    end
    if (wr_last_r) begin
      max_z_eff_s   = max_z_s;
      max_idx_eff_s = max_idx_s;
    end else begin
      max_z_eff_s   = max_z_r;
      max_idx_eff_s = max_idx_r;
    end
  end

  // Registered maximum tracker
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      max_z_r   <= {Z_W{1'b0}};
      max_idx_r <= {SLOT_W{1'b0}};
      wr_last_r <= 1'b0;
    end else begin
      max_z_r   <= max_z_s;
      max_idx_r <= max_idx_s;
      wr_last_r <= wr_en_s;
    end
  end
`endif

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (frame_start_in) next_state_s = SCAN;  else next_state_s = IDLE;
      SCAN:    if (last_issue_s) next_state_s = DRAIN;   else next_state_s = SCAN;
      DRAIN:   if (resp_cnt_r == ALL_BLOCKS) next_state_s = READY; else next_state_s = DRAIN;
      READY:   if (frame_start_in) next_state_s = SCAN;  else next_state_s = READY;
      default: next_state_s = IDLE;
    endcase
  end

  // Control strobes decoded from state and frame start
  always_comb begin
    scan_start_s = 1'b0;
    do_swap_s    = 1'b0;
    late_set_s   = 1'b0;
    last_issue_s = 1'b0;
    case (state_r)
      IDLE:  scan_start_s = frame_start_in;
      SCAN: begin
        late_set_s   = frame_start_in;
        last_issue_s = (issue_cnt_r == LAST_ADDR);
      end
      DRAIN: late_set_s = frame_start_in;
      READY: begin
        scan_start_s = frame_start_in;
        do_swap_s    = frame_start_in;
      end
      default: scan_start_s = 1'b0;
    endcase
  end

  // Response filtering and shadow slot selection
  always_comb begin
    beat_s     = mem_valid_in && resp_en_r && (resp_cnt_r != ALL_BLOCKS) && !scan_start_s;
    eligible_s = beat_s && mem_visible_in && z_in_window(mem_z_in, cam_z_r);
    full_s     = (fill_cnt_r == SLOTS_FULL);
    fill_s     = eligible_s && !full_s;
    drop_s     = eligible_s && full_s;
    wr_data_s  = '{x: mem_x_in, y: mem_y_in, z: mem_z_in, color: mem_color_in,
                   direction: mem_direction_in, id: resp_cnt_r[ID_W-1:0], visible: 1'b1};
`ifdef NEAREST_REPLACE_EN
    if (drop_s && (mem_z_in < max_z_eff_s)) begin
      wr_en_s  = 1'b1;
      wr_idx_s = max_idx_eff_s;
    end else begin
      wr_en_s  = fill_s;
      wr_idx_s = fill_cnt_r;
    end
`else
    wr_en_s  = fill_s;
    wr_idx_s = fill_cnt_r;
`endif
  end

  // Counters, latched camera Z and registered status outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      issue_cnt_r <= 8'd0;
      resp_cnt_r  <= {CNT_W{1'b0}};
      fill_cnt_r  <= {SLOT_W{1'b0}};
      cam_z_r     <= {Z_W{1'b0}};
      resp_en_r   <= 1'b0;
      rd_r        <= 1'b0;
      busy_r      <= 1'b0;
      swap_r      <= 1'b0;
      overflow_r  <= 1'b0;
      late_r      <= 1'b0;
    end else begin
      rd_r   <= (next_state_s == SCAN);
      busy_r <= (next_state_s == SCAN) || (next_state_s == DRAIN);
      swap_r <= do_swap_s;
      if (scan_start_s) begin
        issue_cnt_r <= 8'd0;
        resp_cnt_r  <= {CNT_W{1'b0}};
        fill_cnt_r  <= {SLOT_W{1'b0}};
        cam_z_r     <= cam_z_in;
        resp_en_r   <= 1'b1;
        overflow_r  <= 1'b0;
      end else begin
        if ((state_r == SCAN) && !last_issue_s) issue_cnt_r <= issue_cnt_r + 8'd1;
        if (beat_s) resp_cnt_r <= resp_cnt_r + CNT_W'(1);
        if (fill_s) fill_cnt_r <= fill_cnt_r + SLOT_W'(1);
        if (drop_s) overflow_r <= 1'b1;
      end
      if (do_swap_s) begin
        late_r <= 1'b0;
      end else if (late_set_s) begin
        late_r <= 1'b1;
      end
    end
  end

  assign mem_addr_out = issue_cnt_r;
  assign mem_rd_out   = rd_r;
  assign busy_out     = busy_r;
  assign swap_out     = swap_r;
  assign overflow_out = overflow_r;
  assign late_out     = late_r;

  slot_bank u_slot_bank (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .wr_en           (wr_en_s),
    .wr_idx          (wr_idx_s),
    .wr_data         (wr_data_s),
    .clear_shadow    (scan_start_s),
    .swap            (do_swap_s),
`ifdef NEAREST_REPLACE_EN
    .shadow_z        (shadow_z_s),
`endif
    .block_x         (block_x_out),
    .block_y         (block_y_out),
    .block_z         (block_z_out),
    .block_color     (block_color_out),
    .block_direction (block_direction_out),
    .block_id        (block_ID_out),
    .block_visible   (block_visible_out)
  );

endmodule

// File: tb/tb_block_slot_scheduler.sv
// Bench for block_slot_scheduler: memory responder, frame-level model of the slot
// selection rules, and a per-cycle compare of the active bank against that model.
`timescale 1ns/1ps
module tb_block_slot_scheduler;

  localparam int NS = 12;
  localparam int NB = 256;
  localparam int WZ = 2048;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic         rst_n_in, frame_start_in, mem_valid_in, mem_color_in, mem_visible_in;
  logic [13:0]  cam_z_in, mem_z_in;
  logic [11:0]  mem_x_in, mem_y_in;
  logic [2:0]   mem_direction_in;
  logic [7:0]   mem_addr_out;
  logic         mem_rd_out, swap_out, busy_out, overflow_out, late_out;
  logic [143:0] block_x_out, block_y_out;
  logic [167:0] block_z_out;
  logic [11:0]  block_color_out, block_visible_out;
  logic [35:0]  block_direction_out;
  logic [95:0]  block_ID_out;

  block_slot_scheduler dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .frame_start_in(frame_start_in), .cam_z_in(cam_z_in),
    .mem_addr_out(mem_addr_out), .mem_rd_out(mem_rd_out), .mem_valid_in(mem_valid_in),
    .mem_x_in(mem_x_in), .mem_y_in(mem_y_in), .mem_z_in(mem_z_in), .mem_color_in(mem_color_in),
    .mem_direction_in(mem_direction_in), .mem_visible_in(mem_visible_in),
    .block_x_out(block_x_out), .block_y_out(block_y_out), .block_z_out(block_z_out),
    .block_color_out(block_color_out), .block_direction_out(block_direction_out),
    .block_ID_out(block_ID_out), .block_visible_out(block_visible_out), .swap_out(swap_out),
    .busy_out(busy_out), .overflow_out(overflow_out), .late_out(late_out)
  );

  // memory image
  logic [11:0] m_x [NB];
  logic [11:0] m_y [NB];
  logic [13:0] m_z [NB];
  logic        m_col [NB];
  logic [2:0]  m_dir [NB];
  logic        m_vis [NB];

  // expected state
  logic [49:0] exp_act [NS];
  logic [49:0] pend [NS];
  logic [11:0] exp_act_vis = 12'd0;
  logic [11:0] pend_vis = 12'd0;
  logic        pend_ovf = 1'b0;
  logic        exp_swap = 1'b0;
  logic        exp_late = 1'b0;
  int          bstate = 0;   // 0 idle, 1 scanning, 2 scan complete

  int n_chk = 0;
  int n_fail = 0;

  int cyc = 0;
  int req_cnt = 0;
  int lat_min = 2;
  int lat_max = 2;
  bit gap_en = 1'b0;
  int q_addr[$];
  int q_due[$];

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [49:0] dut_word(input int i);
    return {block_x_out[i*12 +: 12], block_y_out[i*12 +: 12], block_z_out[i*14 +: 14],
            block_color_out[i], block_direction_out[i*3 +: 3], block_ID_out[i*8 +: 8]};
  endfunction

  // Frame-level model: walk memory in address order applying the selection rules
  task automatic model_scan(input int cam);
    int n;
    int pz [NS];
    n = 0;
    pend_vis = 12'd0;
    pend_ovf = 1'b0;
    for (int a = 0; a < NB; a++) begin
      if (m_vis[a] && int'(m_z[a]) >= cam && int'(m_z[a]) < cam + WZ) begin
        if (n < NS) begin
          pend[n] = {m_x[a], m_y[a], m_z[a], m_col[a], m_dir[a], 8'(a)};
          pz[n] = int'(m_z[a]);
          pend_vis[n] = 1'b1;
          n++;
        end else begin
          pend_ovf = 1'b1;
`ifdef NEAREST_REPLACE_EN
          begin
            int k;
            k = 0;
            for (int j = 1; j < NS; j++) if (pz[j] > pz[k]) k = j;
            if (int'(m_z[a]) < pz[k]) begin
              pend[k] = {m_x[a], m_y[a], m_z[a], m_col[a], m_dir[a], 8'(a)};
              pz[k] = int'(m_z[a]);
            end
          end
`endif
        end
      end
    end
  endtask

  task automatic mem_clear();
    for (int a = 0; a < NB; a++) begin
      m_x[a] = 12'(a * 3 + 1);
      m_y[a] = 12'(4095 - a);
      m_z[a] = 14'd100;
      m_col[a] = a[0];
      m_dir[a] = 3'(a);
      m_vis[a] = 1'b0;
    end
  endtask

  task automatic mem_set(input int a, input int z);
    m_vis[a] = 1'b1;
    m_z[a] = 14'(z);
  endtask

  // Request capture: addresses must be sequential and stop after the last block
  initial begin
    forever begin
      @(negedge clk_in);
      if (mem_rd_out === 1'b1) begin
        check("addr_seq", 64'(mem_addr_out), 64'(req_cnt[7:0]));
        check("rd_in_range", 64'(req_cnt < NB), 64'd1);
        q_addr.push_back(int'(mem_addr_out));
        q_due.push_back(cyc + 1 + int'($urandom_range(lat_min, lat_max)));
        req_cnt++;
      end
    end
  end

  // In-order responder with optional random gaps
  initial begin
    int a;
    mem_valid_in = 1'b0; mem_x_in = 12'd0; mem_y_in = 12'd0; mem_z_in = 14'd0;
    mem_color_in = 1'b0; mem_direction_in = 3'd0; mem_visible_in = 1'b0;
    forever begin
      @(posedge clk_in); #1;
      if (q_addr.size() > 0 && q_due[0] <= cyc + 1 && !(gap_en && $urandom_range(0, 2) == 0)) begin
        a = q_addr.pop_front();
        void'(q_due.pop_front());
        mem_valid_in = 1'b1; mem_x_in = m_x[a]; mem_y_in = m_y[a]; mem_z_in = m_z[a];
        mem_color_in = m_col[a]; mem_direction_in = m_dir[a]; mem_visible_in = m_vis[a];
      end else begin
        mem_valid_in = 1'b0;
      end
    end
  end

  // Per-cycle compare of the active bank and the swap/late flags
  initial begin
    forever begin
      @(negedge clk_in);
      check("visible", 64'(block_visible_out), 64'(exp_act_vis));
      for (int i = 0; i < NS; i++)
        if (exp_act_vis[i]) check($sformatf("slot%0d", i), 64'(dut_word(i)), 64'(exp_act[i]));
      check("swap_out", 64'(swap_out), 64'(exp_swap));
      check("late_out", 64'(late_out), 64'(exp_late));
    end
  end

  task automatic apply_reset();
    rst_n_in = 1'b0;
    exp_act_vis = 12'd0; exp_swap = 1'b0; exp_late = 1'b0; bstate = 0;
    #1;
    check("rst_vis", 64'(block_visible_out), 64'd0);
    check("rst_fields", 64'(|{block_x_out, block_y_out, block_z_out, block_color_out,
                              block_direction_out, block_ID_out}), 64'd0);
    check("rst_flags", 64'({swap_out, busy_out, overflow_out, late_out, mem_rd_out}), 64'd0);
    check("rst_addr", 64'(mem_addr_out), 64'd0);
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
  endtask

  // Caller is at posedge+1; drives a one-cycle frame start and updates expectations
  task automatic pulse_fs(input int cam);
    bit do_swap, do_start;
    do_swap  = (bstate == 2);
    do_start = (bstate != 1);
    cam_z_in = 14'(cam);
    frame_start_in = 1'b1;
    if (do_start) req_cnt = 0;
    @(posedge clk_in); #1;
    frame_start_in = 1'b0;
    if (do_swap) begin
      exp_act = pend;
      exp_act_vis = pend_vis;
      exp_swap = 1'b1;
      exp_late = 1'b0;
    end else if (bstate == 1) begin
      exp_late = 1'b1;
    end
    if (do_start) begin
      model_scan(cam);
      bstate = 1;
    end
    check("busy_after_fs", 64'(busy_out), 64'd1);
    @(posedge clk_in); #1;
    exp_swap = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!(req_cnt == NB && q_addr.size() == 0) && t < 3000) begin
      @(posedge clk_in); #1;
      t++;
    end
    check("scan_timeout", 64'(t < 3000), 64'd1);
    repeat (4) @(posedge clk_in);
    #1;
    check("busy_done", 64'(busy_out), 64'd0);
    check("overflow", 64'(overflow_out), 64'(pend_ovf));
    bstate = 2;
  endtask

  task automatic pattern_s1();
    mem_clear();
    mem_set(3, 100); mem_set(10, 100); mem_set(200, 100);
  endtask

  task automatic check_s1_ids(input string tag);
    check({tag, "_id0"}, 64'(block_ID_out[7:0]), 64'd3);
    check({tag, "_id1"}, 64'(block_ID_out[15:8]), 64'd10);
    check({tag, "_id2"}, 64'(block_ID_out[23:16]), 64'd200);
    check({tag, "_vis"}, 64'(block_visible_out), 64'h007);
  endtask

  initial begin
    int t;
    rst_n_in = 1'b1; frame_start_in = 1'b0; cam_z_in = 14'd0;
    mem_clear();
    #2;
    apply_reset();

    // 1: three visible blocks, latency 2
    pattern_s1();
    pulse_fs(0);
    wait_done();
    check("s1_ovf", 64'(overflow_out), 64'd0);
    pulse_fs(0);
    check_s1_ids("s1");
    wait_done();

    // 2: 20 eligible blocks with descending Z
    mem_clear();
    for (int i = 0; i < 20; i++) mem_set(i, 1000 - i);
    pulse_fs(0);
    wait_done();
    check("s2_ovf", 64'(overflow_out), 64'd1);
    pulse_fs(0);
    check("s2_vis", 64'(block_visible_out), 64'hFFF);
`ifdef NEAREST_REPLACE_EN
    check("s2_id0", 64'(block_ID_out[7:0]), 64'd12);
    check("s2_z0", 64'(block_z_out[13:0]), 64'd988);
`else
    check("s2_id0", 64'(block_ID_out[7:0]), 64'd0);
    check("s2_z0", 64'(block_z_out[13:0]), 64'd1000);
`endif
    check("s2_id11", 64'(block_ID_out[95:88]), 64'd11);
    wait_done();

    // 3: window edges at cam_z=16000, no wrap past 14 bits
    mem_clear();
    mem_set(5, 15999); mem_set(6, 16000); mem_set(7, 16383); mem_set(8, 0); mem_set(9, 1663);
    pulse_fs(16000);
    wait_done();
    pulse_fs(16000);
    check("s3_vis", 64'(block_visible_out), 64'h003);
    check("s3_id0", 64'(block_ID_out[7:0]), 64'd6);
    check("s3_id1", 64'(block_ID_out[15:8]), 64'd7);
    wait_done();

    // 4: late frame start 50 cycles into the scan
    mem_clear();
    for (int a = 0; a < NB; a += 20) mem_set(a, 500);
    pulse_fs(0);
    repeat (50) @(posedge clk_in);
    #1;
    pulse_fs(0);
    check("s4_late", 64'(late_out), 64'd1);
    check("s4_active_kept", 64'(block_visible_out), 64'h003);
    wait_done();
    pulse_fs(0);
    check("s4_late_clr", 64'(late_out), 64'd0);
    check("s4_vis", 64'(block_visible_out), 64'hFFF);
    check("s4_id11", 64'(block_ID_out[95:88]), 64'd220);
    wait_done();

    // 5: reset during DRAIN, then a clean scan
    pattern_s1();
    pulse_fs(0);
    t = 0;
    while (req_cnt < NB && t < 1000) begin
      @(posedge clk_in); #1;
      t++;
    end
    check("s5_reach_drain", 64'(t < 1000), 64'd1);
    @(posedge clk_in); #1;
    check("s5_busy_drain", 64'(busy_out), 64'd1);
    apply_reset();
    t = 0;
    while (q_addr.size() > 0 && t < 100) begin
      @(posedge clk_in); #1;
      t++;
    end
    repeat (3) @(posedge clk_in);
    #1;
    lat_min = 3; lat_max = 3;
    pulse_fs(0);
    wait_done();
    pulse_fs(0);
    check_s1_ids("s5");
    wait_done();

    // 6: variable latency with random gaps
    lat_min = 1; lat_max = 6; gap_en = 1'b1;
    pulse_fs(0);
    wait_done();
    pulse_fs(0);
    check_s1_ids("s6");
    wait_done();
    gap_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
